llr_sat_pipe: RTL and testbench
===============================

Name: llr_sat_pipe

Overview:
- Multi-lane, pipelined LLR quantiser: each lane arithmetic-shifts a wide signed sum, optionally rounds, then clamps it to the message width.
- Sits between the check/variable-node adders and the message memories of the min-sum decoder.
- Replaces the single-lane combinational clamp on the message path.
- Adds valid/ready flow control, a symmetric-range mode and per-lane saturation flags.

Parameters:
- LANES, 4: number of independent lanes processed per beat.
- IN_W, 12: signed input width per lane.
- OUT_W, 8: signed output width per lane; must satisfy OUT_W < IN_W.
- SHIFT, 0: arithmetic right shift applied before the clamp, range 0..IN_W-OUT_W.
- ROUND, 0: 1 = round half away from zero when SHIFT>0; 0 = truncate toward minus infinity.
- SYMMETRIC, 1: 1 = negative limit is -(2^(OUT_W-1)-1); 0 = negative limit is -2^(OUT_W-1).
- CNT_W, 16: width of the saturation counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat when in_valid & in_ready.
- in_data  in  LANES*IN_W  lane i occupies bits [i*IN_W +: IN_W], two's complement.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*OUT_W  lane i occupies bits [i*OUT_W +: OUT_W].
- out_sat  out  LANES  per-lane flag: that lane was clamped.
- sat_cnt_clr  in  1  (LLR_SAT_STATS_EN only) synchronous clear of sat_cnt.
- sat_cnt  out  CNT_W  (LLR_SAT_STATS_EN only) count of clamped lane-samples.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - s1_valid, s2_valid, out_valid, out_data, out_sat and sat_cnt all go to 0.
  - Data registers also clear.
  - Reset mid-stream drops all in-flight beats.
- Pipeline: two register stages, latency 2 cycles from an accepted input to out_valid when unstalled.
- Stage 1 (scale):
  - If SHIFT=0, t = sign-extended x.
  - If SHIFT>0 and ROUND=0, t = x >>> SHIFT.
  - If SHIFT>0 and ROUND=1:
    - x >= 0: t = (x + 2^(SHIFT-1)) >>> SHIFT.
    - x < 0: t = -((-x + 2^(SHIFT-1)) >>> SHIFT).
  - t is held at IN_W+1 bits, so neither -x nor the round increment can overflow.
- Stage 2 (clamp):
  - t > MAX = 2^(OUT_W-1)-1: output MAX, flag = 1.
  - t < MIN (MIN set by SYMMETRIC): output MIN, flag = 1.
  - Otherwise output t[OUT_W-1:0], flag = 0.
  - With SYMMETRIC=1, an exact input of -2^(OUT_W-1) is clamped and flagged.
- Flow control (global stall):
  - adv = ~out_valid | out_ready; in_ready = adv.
  - When adv=1, both stages shift together:
    - s1 loads the input beat with valid = in_valid.
    - s2 loads s1.
  - When adv=0, all registers hold. out_data and out_sat must stay stable while out_valid & ~out_ready.
  - Bubbles propagate; they are not collapsed.
  - in_ready may depend combinationally on out_ready. There is no path from in_valid to in_ready.
- Simultaneous accept and output with out_ready=1: full throughput, one beat per cycle.
- Lanes are fully independent. A flag on one lane never affects another lane.

Optional Feature:
- Macro: LLR_SAT_STATS_EN.
- Defined:
  - sat_cnt_clr and sat_cnt ports exist.
  - On each output handshake (out_valid & out_ready), sat_cnt += popcount(out_sat), saturating at 2^CNT_W-1 (it does not wrap).
  - sat_cnt_clr has priority over the increment in the same cycle; the count lost in that cycle is dropped.
- Undefined: the ports and counter logic are absent. Datapath behaviour is identical either way.

Decomposition:
- Shared include ct.vh gains:
  - the LLR_SAT_STATS_EN default (undefined);
  - localparam helpers for MAX/MIN limit computation;
  - the default widths LLR_IN_W and LLR_OUT_W, used by the decoder top.
- Sub-module llr_sat_lane: one-lane combinational scale-and-clamp, split at the stage-1/stage-2 boundary via a registered intermediate. It is instantiated LANES times in a generate loop. The pipeline registers, handshake and counter stay in llr_sat_pipe.

Test Plan:
- Defaults, lanes = {100, -100, 127, -127}, out_ready=1 → two cycles later out_data={100,-100,127,-127}, out_sat=0000.
- Defaults, lanes = {2047, -2048, 128, -128} → {127, -127, 127, -127}, out_sat=1111. With SYMMETRIC=0, lane 3 = -128 and flag = 0.
- SHIFT=2, ROUND=1, lanes = {6, -6, 5, -5} → {2, -2, 1, -1}. With ROUND=0 → {1, -2, 1, -2}.
- Stream 8 beats with out_ready toggling 1,0,0,1,…:
  - every beat arrives exactly once, in order;
  - out_data is stable whenever it is stalled;
  - in_ready=0 exactly when out_valid & ~out_ready.
- Drop rst_n for 1 cycle while 2 beats are in flight → out_valid=0 next cycle, no stale beat emitted, and sat_cnt=0.
- LLR_SAT_STATS_EN, CNT_W=4: send 5 beats each with 4 saturating lanes → sat_cnt=15, held. Assert sat_cnt_clr together with a saturating handshake → sat_cnt=0.

Source files
------------

// File: rtl/llr_sat_pipe_pkg.sv
// llr_sat_pipe_pkg
//   Shared constants and helpers for the LLR quantiser.
//   - LLR_IN_W / LLR_OUT_W : default sum and message widths used by the decoder top.
//   - llr_max / llr_min    : clamp limits for a given message width and range mode.
//   Optional feature macro LLR_SAT_STATS_EN is left undefined by default.
package llr_sat_pipe_pkg;

  localparam int LLR_IN_W  = 12;
  localparam int LLR_OUT_W = 8;

  // Largest positive message value: 2^(out_w-1)-1.
  function automatic int llr_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // Most negative message value; symmetric mode mirrors the positive limit.
  function automatic int llr_min(input int out_w, input bit sym);
    return sym ? -((1 << (out_w - 1)) - 1) : -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/llr_sat_pipe_lane.sv
// llr_sat_lane
//   One-lane scale-and-clamp, purely combinational. The scale half produces t
//   from x; the clamp half works on t_q, the registered copy of t held by the
//   caller, so the two halves sit on either side of a pipeline register.
//   Ports:
//     x   in  IN_W     signed input sample
//     t   out IN_W+1   scaled sample (shift, optional round)
//     t_q in  IN_W+1   registered scaled sample
//     y   out OUT_W    clamped message
//     sat out 1        y was clamped
module llr_sat_lane
  import llr_sat_pipe_pkg::*;
#(
  parameter int IN_W      = LLR_IN_W,
  parameter int OUT_W     = LLR_OUT_W,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int SYMMETRIC = 1
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [IN_W:0]    t,
  input  logic signed [IN_W:0]    t_q,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(llr_max(OUT_W));
  localparam logic signed [IN_W:0] MINV = (IN_W+1)'(llr_min(OUT_W, SYMMETRIC != 0));

  // One extra bit of headroom so negation of the most negative input and the
  // rounding increment cannot overflow.
  logic signed [IN_W:0] xe;
  assign xe = {x[IN_W-1], x};

  generate
    if (SHIFT == 0) begin : g_pass
      assign t = xe;
    end else if (ROUND == 0) begin : g_trunc
      assign t = xe >>> SHIFT;
    end else begin : g_round
      // Round half away from zero: round the magnitude, then restore the sign.
      logic signed [IN_W:0] mag;
      logic signed [IN_W:0] rnd;
      assign mag = xe[IN_W] ? -xe : xe;
      assign rnd = (mag + (IN_W+1)'(1 << (SHIFT - 1))) >>> SHIFT;
      assign t   = xe[IN_W] ? -rnd : rnd;
    end
  endgenerate

  always_comb begin
    y   = t_q[OUT_W-1:0];
    sat = 1'b0;
    if (t_q > MAXV) begin
      y   = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (t_q < MINV) begin
      y   = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/llr_sat_pipe.sv
// llr_sat_pipe
//   Multi-lane pipelined LLR quantiser: per lane, arithmetic shift (optional
//   rounding) of a wide signed sum, then clamp to the message width. Two
//   register stages, global stall, valid/ready on both sides.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     in_valid/in_ready     input handshake (in_ready = ~out_valid | out_ready)
//     in_data               LANES x IN_W signed, lane i at [i*IN_W +: IN_W]
//     out_valid/out_ready   output handshake
//     out_data              LANES x OUT_W signed, lane i at [i*OUT_W +: OUT_W]
//     out_sat               per-lane clamp flag
//     sat_cnt_clr, sat_cnt  (LLR_SAT_STATS_EN) saturating count of clamped lane-samples
//   Macro: LLR_SAT_STATS_EN enables the saturation counter and its ports.
module llr_sat_pipe
  import llr_sat_pipe_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int IN_W      = LLR_IN_W,
  parameter int OUT_W     = LLR_OUT_W,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int SYMMETRIC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat
`ifdef LLR_SAT_STATS_EN
  ,
  input  logic                   sat_cnt_clr,
  output logic [CNT_W-1:0]       sat_cnt
`endif
);

  localparam int TW = IN_W + 1;

  if (OUT_W >= IN_W || SHIFT < 0 || SHIFT > IN_W - OUT_W || CNT_W < 1) begin : g_bad_params
    $error("llr_sat_pipe: illegal parameter combination");
  end

  logic                   adv;
  logic                   s1_valid;
  logic [LANES*TW-1:0]    s1_t;
  logic [LANES*TW-1:0]    t_d;
  logic [LANES*OUT_W-1:0] y_d;
  logic [LANES-1:0]       sat_d;

  // Global stall: the whole pipe advances only when the output slot frees up.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    llr_sat_lane #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .SHIFT    (SHIFT),
      .ROUND    (ROUND),
      .SYMMETRIC(SYMMETRIC)
    ) u_lane (
      .x  (in_data[i*IN_W +: IN_W]),
      .t  (t_d[i*TW +: TW]),
      .t_q(s1_t[i*TW +: TW]),
      .y  (y_d[i*OUT_W +: OUT_W]),
      .sat(sat_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_t      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_t      <= t_d;
      out_valid <= s1_valid;
      out_data  <= y_d;
      out_sat   <= sat_d;
    end
  end

`ifdef LLR_SAT_STATS_EN
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = CNT_W + PW;

  logic [PW-1:0] pop;
  logic [SW-1:0] sum;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop = pop + PW'(out_sat[i]);
    end
  end

  assign sum = SW'(sat_cnt) + SW'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sat_cnt <= (sum > SW'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_llr_sat_pipe.sv
module tb_llr_sat_pipe;

  localparam int L  = 4;
  localparam int IW = 12;
  localparam int OW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, in_valid, out_ready, sat_cnt_clr;
  logic [L*IW-1:0] in_data;

  // d_: defaults, a_: SYMMETRIC=0, r_: SHIFT=2 ROUND=1, t_: SHIFT=2 ROUND=0
  logic            d_ir, a_ir, r_ir, t_ir;
  logic            d_ov, a_ov, r_ov, t_ov;
  logic [L*OW-1:0] d_od, a_od, r_od, t_od;
  logic [L-1:0]    d_os, a_os, r_os, t_os;
`ifdef LLR_SAT_STATS_EN
  logic [3:0]      d_cnt;
  logic [15:0]     a_cnt, r_cnt, t_cnt;
`endif

  llr_sat_pipe #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_ir), .in_data(in_data),
    .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od), .out_sat(d_os)
`ifdef LLR_SAT_STATS_EN
    , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(d_cnt)
`endif
  );

  llr_sat_pipe #(.SYMMETRIC(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_sat(a_os)
`ifdef LLR_SAT_STATS_EN
    , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(a_cnt)
`endif
  );

  llr_sat_pipe #(.SHIFT(2), .ROUND(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_ir), .in_data(in_data),
    .out_valid(r_ov), .out_ready(out_ready), .out_data(r_od), .out_sat(r_os)
`ifdef LLR_SAT_STATS_EN
    , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(r_cnt)
`endif
  );

  llr_sat_pipe #(.SHIFT(2), .ROUND(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_ir), .in_data(in_data),
    .out_valid(t_ov), .out_ready(out_ready), .out_data(t_od), .out_sat(t_os)
`ifdef LLR_SAT_STATS_EN
    , .sat_cnt_clr(sat_cnt_clr), .sat_cnt(t_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [L*IW-1:0] pin(input int a, input int b, input int c, input int d);
    return {d[IW-1:0], c[IW-1:0], b[IW-1:0], a[IW-1:0]};
  endfunction

  function automatic logic [L*OW-1:0] pout(input int a, input int b, input int c, input int d);
    return {d[OW-1:0], c[OW-1:0], b[OW-1:0], a[OW-1:0]};
  endfunction

  typedef struct {
    logic [L*IW-1:0] x;
    logic [L*OW-1:0] yd; logic [L-1:0] sd;
    logic [L*OW-1:0] ya; logic [L-1:0] sa;
    logic [L*OW-1:0] yr; logic [L-1:0] sr;
    logic [L*OW-1:0] yt; logic [L-1:0] st;
  } vec_t;

  vec_t vt[6];

  logic [L*OW-1:0] expq[$];
  logic [L*OW-1:0] exp_beat;
  logic [L*OW-1:0] prev_data;
  bit              m1, m2, adv, stall_prev;
  int              sent, got;
  bit              rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    vt[0] = '{pin(100, -100, 127, -127),
              pout(100, -100, 127, -127), 4'b0000, pout(100, -100, 127, -127), 4'b0000,
              pout(25, -25, 32, -32), 4'b0000, pout(25, -25, 31, -32), 4'b0000};
    vt[1] = '{pin(2047, -2048, 128, -128),
              pout(127, -127, 127, -127), 4'b1111, pout(127, -128, 127, -128), 4'b0111,
              pout(127, -127, 32, -32), 4'b0011, pout(127, -127, 32, -32), 4'b0011};
    vt[2] = '{pin(6, -6, 5, -5),
              pout(6, -6, 5, -5), 4'b0000, pout(6, -6, 5, -5), 4'b0000,
              pout(2, -2, 1, -1), 4'b0000, pout(1, -2, 1, -2), 4'b0000};
    vt[3] = '{pin(0, -1, -128, 2047),
              pout(0, -1, -127, 127), 4'b1100, pout(0, -1, -128, 127), 4'b1000,
              pout(0, 0, -32, 127), 4'b1000, pout(0, -1, -32, 127), 4'b1000};
    vt[4] = '{pin(129, -129, 2, -2),
              pout(127, -127, 2, -2), 4'b0011, pout(127, -128, 2, -2), 4'b0011,
              pout(32, -32, 1, -1), 4'b0000, pout(32, -33, 0, -1), 4'b0000};
    vt[5] = '{pin(508, -508, 510, -512),
              pout(127, -127, 127, -127), 4'b1111, pout(127, -128, 127, -128), 4'b1111,
              pout(127, -127, 127, -127), 4'b1100, pout(127, -127, 127, -127), 4'b1000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; sat_cnt_clr = 1'b0;
    step(); step();
    check("rst_out_valid", {60'd0, d_ov, a_ov, r_ov, t_ov}, 64'd0);
    check("rst_out_data", d_od, 64'd0);
    check("rst_out_sat", d_os, 64'd0);
    check("rst_in_ready", d_ir, 64'd1);
`ifdef LLR_SAT_STATS_EN
    check("rst_sat_cnt", d_cnt, 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // Table vectors: one beat each, checked at exactly two cycles latency.
    for (int i = 0; i < 6; i++) begin
      in_data = vt[i].x; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_lat1_valid", i), {60'd0, d_ov, a_ov, r_ov, t_ov}, 64'd0);
      step();
      check($sformatf("v%0d_valid", i), {60'd0, d_ov, a_ov, r_ov, t_ov}, 64'hF);
      check($sformatf("v%0d_def_data", i), d_od, vt[i].yd);
      check($sformatf("v%0d_def_sat", i), d_os, vt[i].sd);
      check($sformatf("v%0d_asym_data", i), a_od, vt[i].ya);
      check($sformatf("v%0d_asym_sat", i), a_os, vt[i].sa);
      check($sformatf("v%0d_rnd_data", i), r_od, vt[i].yr);
      check($sformatf("v%0d_rnd_sat", i), r_os, vt[i].sr);
      check($sformatf("v%0d_trn_data", i), t_od, vt[i].yt);
      check($sformatf("v%0d_trn_sat", i), t_os, vt[i].st);
    end
    step(); step();

    // Streaming with backpressure pattern 1,0,0,1 against a valid-pipeline model.
    m1 = 0; m2 = 0; stall_prev = 0; sent = 0; got = 0; prev_data = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      out_ready = rdy_pat[cyc % 4];
      in_valid  = (sent < 8);
      in_data   = pin(sent * 7, -sent * 5, sent + 1, -sent - 100);
      #1;
      adv = !m2 || out_ready;
      check("strm_out_valid", d_ov, {63'd0, m2});
      check("strm_in_ready", d_ir, {63'd0, adv});
      if (stall_prev) check("strm_hold", d_od, prev_data);
      if (m2 && out_ready) begin
        if (expq.size() == 0) begin
          check("strm_extra_beat", 64'd1, 64'd0);
        end else begin
          exp_beat = expq.pop_front();
          check($sformatf("strm_beat%0d", got), d_od, exp_beat);
        end
        got++;
      end
      if (in_valid && adv) begin
        expq.push_back(pout(sent * 7, -sent * 5, sent + 1, -sent - 100));
        sent++;
      end
      stall_prev = m2 && !out_ready;
      prev_data  = d_od;
      if (adv) begin
        m2 = m1;
        m1 = in_valid;
      end
      step();
    end
    check("strm_count", got, 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    // Reset with two beats in flight: nothing stale may come out.
    in_data = vt[1].x; in_valid = 1'b1;
    step();
    in_data = vt[5].x;
    step();
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_valid", {60'd0, d_ov, a_ov, r_ov, t_ov}, 64'd0);
    check("mid_rst_data", d_od, 64'd0);
    check("mid_rst_sat", d_os, 64'd0);
`ifdef LLR_SAT_STATS_EN
    check("mid_rst_cnt", d_cnt, 64'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_valid", d_ov, 64'd0);
    end

`ifdef LLR_SAT_STATS_EN
    // Five beats with four clamped lanes each saturate a 4-bit counter at 15.
    in_data = vt[1].x;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    check("cnt_sat15", d_cnt, 64'd15);
    step(); step();
    check("cnt_hold15", d_cnt, 64'd15);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("cnt_clr_pre_valid", d_ov, 64'd1);
    sat_cnt_clr = 1'b1;
    step();
    sat_cnt_clr = 1'b0;
    check("cnt_clr_wins", d_cnt, 64'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("cnt_after_clr", d_cnt, 64'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
